// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer state encoding
// and the pc value presented to DM for debug-port writes.
package dm_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arbState_e;

  localparam logic [31:0] PC_DEBUG = 32'hFFFF_FFFF;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the MEM-stage port (c_*), the debug port (d_*) and the DM port (mem_*).
// slave is the arbiter's view; master is the surrounding pipeline, debugger and DM.
interface dm_arbiter_if;

  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_pc;
  logic        c_gnt;
  logic [31:0] c_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_pc,
    output c_gnt, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rdata, d_err,
    output mem_addr, mem_wdata, mem_we, mem_pc,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_pc,
    input  c_gnt, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rdata, d_err,
    input  mem_addr, mem_wdata, mem_we, mem_pc,
    output mem_rdata
  );

endinterface

// File: rtl/dm_clear_seq.sv
// CLEAR/RUN sequencer: walks clrPtr over every DM word after reset or on
// request, then hands DM back to the arbiter.
module dm_clear_seq
  import dm_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int PTR_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clrStart,
  output arbState_e        state,
  output logic [PTR_W-1:0] clrPtr
);

  arbState_e        stateNext;
  logic [PTR_W-1:0] ptrNext;
  logic             clrDone;

  assign clrDone = (state == CLEAR) && (clrPtr == PTR_W'(DEPTH_WORDS - 1));

  // NOTE: registers take <= so every flop samples pre-edge values; = here would race.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= CLEAR;
      clrPtr <= '0;
    end else begin
      state  <= stateNext;
      clrPtr <= ptrNext;
    end
  end

  // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
  always_comb begin
    stateNext = state;
    ptrNext   = clrPtr;
    unique case (state)
      CLEAR: begin
        if (clrDone) begin
          stateNext = RUN;
          ptrNext   = '0;
        end else begin
          ptrNext = clrPtr + PTR_W'(1);
        end
      end
      RUN: begin
        if (clrStart) begin
          stateNext = CLEAR;
          ptrNext   = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares single-port DM between the MEM stage (C, fixed priority) and the debug
// port (D, forced through after STARVE_MAX lost cycles); owns DM clearing.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int STARVE_MAX  = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr_start,
  output logic         clr_busy,
  dm_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arbState_e        state;
  logic [PTR_W-1:0] clrPtr;
  logic [CNT_W-1:0] starveCnt;
  logic             cGnt;
  logic             dGnt;
  logic             dErr;

  dm_clear_seq #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .PTR_W       (PTR_W)
  ) uClearSeq (
    .Clk      (Clk),
    .Reset    (Reset),
    .clrStart (clr_start),
    .state    (state),
    .clrPtr   (clrPtr)
  );

  // Zero-cycle grant: C wins unless D has already lost STARVE_MAX cycles in a row.
  always_comb begin
    cGnt = 1'b0;
    dGnt = 1'b0;
    if (state == RUN) begin
      dGnt = bus.d_req && (!bus.c_req || (starveCnt == CNT_W'(STARVE_MAX)));
      cGnt = bus.c_req && !dGnt;
    end
  end

  assign dErr = dGnt && (bus.d_addr[31:2] >= 30'(DEPTH_WORDS));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      starveCnt <= '0;
    end else if (!bus.d_req || dGnt) begin
      starveCnt <= '0;
    end else if (cGnt && (starveCnt != CNT_W'(STARVE_MAX))) begin
      starveCnt <= starveCnt + CNT_W'(1);
    end
  end

  // mem_we follows Reset during CLEAR so DM sees no write while reset is held.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_pc    = '0;
    if (state == CLEAR) begin
      bus.mem_addr = {{(30 - PTR_W){1'b0}}, clrPtr, 2'b00};
      bus.mem_we   = Reset;
    end else if (cGnt) begin
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
      bus.mem_we    = bus.c_we;
      bus.mem_pc    = bus.c_pc;
    end else if (dGnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_we    = bus.d_we && !dErr;
      bus.mem_pc    = PC_DEBUG;
    end
  end

  assign clr_busy    = (state == CLEAR);
  assign bus.c_gnt   = cGnt;
  assign bus.c_rdata = cGnt ? bus.mem_rdata : '0;
  assign bus.d_gnt   = dGnt;
  assign bus.d_err   = dErr;
  assign bus.d_rdata = (dGnt && !dErr) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed clear/priority/starvation/range scenarios plus
// randomized traffic, all checked against a word-array + wait-count reference model.
module tb_dm_arbiter;

  localparam int DEPTH      = 1024;
  localparam int STARVE_MAX = 4;

  logic Clk;
  logic Reset;
  logic clr_start;
  logic clr_busy;
  logic preload;

  dm_arbiter_if bus ();

  dm_arbiter #(
    .DEPTH_WORDS (DEPTH),
    .STARVE_MAX  (STARVE_MAX)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .bus       (bus)
  );

  // Data memory driven by the DUT's mem_* port (combinational read, write on the edge).
  logic [31:0] dm [DEPTH];
  assign bus.mem_rdata = dm[bus.mem_addr[11:2]];

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) dm[i] <= 32'hA500_0000 | 32'(i);
    end else if (bus.mem_we) begin
      dm[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: expected DM contents and length of the current run of D losing to C.
  logic [31:0] refMem [DEPTH];
  int          waitRun;
  int          nChecks;
  int          nPass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    waitRun = 0;
  endtask

  // One RUN cycle: drive at edge+1, compare at edge+3, advance model and clock.
  task automatic apply(input string tag,
                       input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic [31:0] cpc,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, output logic gotD);
    logic        eC, eD, eErr, eWe;
    logic [31:0] eCr, eDr, eAddr, ePc;
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cwd; bus.c_pc = cpc;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dwd;

    eD    = dr && (!cr || waitRun >= STARVE_MAX);
    eC    = cr && !eD;
    eErr  = eD && (int'(da[31:2]) >= DEPTH || da[31] == 1'b1);
    eCr   = eC ? refMem[ca[11:2]] : 32'h0;
    eDr   = (eD && !eErr) ? refMem[da[11:2]] : 32'h0;
    eWe   = (eC && cw) || (eD && dw && !eErr);
    eAddr = eC ? ca : (eD ? da : 32'h0);
    ePc   = eC ? cpc : (eD ? 32'hFFFF_FFFF : 32'h0);

    #2;
    check({tag, ".c_gnt"},    32'(bus.c_gnt),  32'(eC));
    check({tag, ".d_gnt"},    32'(bus.d_gnt),  32'(eD));
    check({tag, ".d_err"},    32'(bus.d_err),  32'(eErr));
    check({tag, ".mem_we"},   32'(bus.mem_we), 32'(eWe));
    check({tag, ".mem_addr"}, bus.mem_addr,    eAddr);
    check({tag, ".mem_pc"},   bus.mem_pc,      ePc);
    check({tag, ".c_rdata"},  bus.c_rdata,     eCr);
    check({tag, ".d_rdata"},  bus.d_rdata,     eDr);
    gotD = bus.d_gnt;

    if (eC && cw) refMem[ca[11:2]] = cwd;
    if (eD && dw && !eErr) refMem[da[11:2]] = dwd;
    waitRun = (dr && eC) ? waitRun + 1 : 0;
    tick();
  endtask

  // Follows a clear from its first cycle; stops when clr_busy drops or after abortAt words.
  task automatic watch_clear(input int abortAt, input bit pulse,
                             output int len, output int bad, output int gnts);
    bit done;
    done = 1'b0;
    len = 0; bad = 0; gnts = 0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.d_req = 1'b0;
    for (int cyc = 0; cyc < 1100 && !done; cyc++) begin
      clr_start = pulse && (cyc == 100);
      #2;
      if (!clr_busy) begin
        done = 1'b1;
        clr_start = 1'b0;
        tick();
      end else begin
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== (32'(len) << 2) ||
            bus.mem_wdata !== 32'h0 || bus.mem_pc !== 32'h0) bad++;
        if (bus.c_gnt || bus.d_gnt) gnts++;
        len++;
        if (len == abortAt) done = 1'b1;
        else tick();
      end
    end
    clr_start = 1'b0;
    waitRun   = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   len, bad, gnts, nz;
    logic gotD;
    nChecks = 0; nPass = 0; waitRun = 0;
    Reset = 1'b0; clr_start = 1'b0; preload = 1'b0;
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h40; bus.c_wdata = 32'h1; bus.c_pc = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h44; bus.d_wdata = 32'h2;

    // Outputs while reset is held, with both ports requesting writes.
    #3;
    check("rst.clr_busy", 32'(clr_busy),   32'h1);
    check("rst.mem_we",   32'(bus.mem_we), 32'h0);
    check("rst.c_gnt",    32'(bus.c_gnt),  32'h0);
    check("rst.d_gnt",    32'(bus.d_gnt),  32'h0);
    check("rst.d_err",    32'(bus.d_err),  32'h0);
    check("rst.c_rdata",  bus.c_rdata,     32'h0);
    check("rst.d_rdata",  bus.d_rdata,     32'h0);

    preload = 1'b1;
    tick();
    preload = 1'b0;
    tick();

    // Reset release: full clear over nonzero contents.
    Reset = 1'b1;
    watch_clear(0, 1'b0, len, bad, gnts);
    check("clr1.len",  32'(len),  32'd1024);
    check("clr1.seq",  32'(bad),  32'd0);
    check("clr1.gnts", 32'(gnts), 32'd0);
    ref_clear();

    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.c_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'(i) << 2;
      #2;
      if (!bus.d_gnt || bus.d_rdata !== 32'h0) nz++;
      tick();
    end
    check("clr1.all_zero", 32'(nz), 32'd0);

    // C write then read.
    apply("c_wr", 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, gotD);
    apply("c_rd", 1'b1, 1'b0, 32'h10, 32'h0, 32'h404, 1'b0, 1'b0, 32'h0, 32'h0, gotD);

    // Starvation: D forced through on every fifth cycle of contention.
    for (int k = 0; k < 15; k++) begin
      apply("starve", 1'b1, 1'b0, 32'h10, 32'h0, 32'h408, 1'b1, 1'b0, 32'h20, 32'h0, gotD);
      check("starve.pattern", 32'(gotD), 32'((k % 5) == 4));
    end

    // D out of range and the last valid word.
    apply("oor", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h55, gotD);
    check("oor.word0", dm[0], refMem[0]);
    apply("top_wr", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFC, 32'hCAFE_F00D, gotD);
    apply("top_rd", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFC, 32'h0, gotD);

    // Randomized traffic on a small window so reads hit earlier writes.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ca, da;
      ca = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       da = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
        1:       da = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
        default: da = 32'($urandom_range(0, 15)) << 2;
      endcase
      apply("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ca, $urandom,
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom, gotD);
    end

    // Clear request alongside a C write, then reset part-way through the clear.
    clr_start = 1'b1;
    apply("clr_wr", 1'b1, 1'b1, 32'h8, 32'h1234, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, gotD);
    clr_start = 1'b0;
    check("clr_wr.commit", dm[2], 32'h1234);
    check("clr_wr.busy",   32'(clr_busy), 32'h1);
    watch_clear(500, 1'b0, len, bad, gnts);
    check("clr2.len",  32'(len), 32'd500);
    check("clr2.seq",  32'(bad), 32'd0);
    #1;
    Reset = 1'b0;
    #1;
    check("clr2.rst_we",   32'(bus.mem_we), 32'h0);
    check("clr2.rst_busy", 32'(clr_busy),   32'h1);
    tick();
    Reset = 1'b1;
    watch_clear(0, 1'b1, len, bad, gnts);
    check("clr3.len",  32'(len),  32'd1024);
    check("clr3.seq",  32'(bad),  32'd0);
    check("clr3.gnts", 32'(gnts), 32'd0);
    ref_clear();
    apply("clr_rd", 1'b1, 1'b0, 32'h8, 32'h0, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, gotD);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
